// File: rtl/ahb_arb_pkg.sv
// Shared definitions for the two-requester AHB command arbiter:
// FSM state encoding, burst type codes and the burst length decode.
package ahb_arb_pkg;

    localparam int CW_PKG = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam logic [2:0] BT_SINGLE = 3'b000;
    localparam logic [2:0] BT_INCR4  = 3'b011;
    localparam logic [2:0] BT_INCR8  = 3'b101;
    localparam logic [2:0] BT_INCR16 = 3'b111;

    // Beats in a burst; any code we do not support degrades to a single beat.
    function automatic logic [CW_PKG-1:0] burst_len(input logic [2:0] bt);
        case (bt)
            BT_INCR4:  burst_len = 5'd4;
            BT_INCR8:  burst_len = 5'd8;
            BT_INCR16: burst_len = 5'd16;
            default:   burst_len = 5'd1;
        endcase
    endfunction

endpackage

// File: rtl/ahb_req_arbiter_rr_pick2.sv
// Combinational round-robin pick between two requesters.
// sel=1 means requester 1 wins; on a tie the one that did not go last wins.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic sel,
    output logic any
);

    assign any = req0 | req1;
    assign sel = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/ahb_req_arbiter.sv
// Two-requester arbiter/sequencer in front of the AHB master datapath.
// Latches the winning command, steps the burst one beat per hready and
// inserts one idle TURN cycle after each burst before re-arbitrating.
module ahb_req_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 11,
    parameter int CW = 5
) (
    input  logic          hclk,
    input  logic          resetn,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          wr0,
    input  logic [2:0]    burst0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          wr1,
    input  logic [2:0]    burst1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          ack0,
    output logic          ack1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          m_valid,
    output logic [AW-1:0] m_addr,
    output logic          m_wr,
    output logic [2:0]    m_burst,
    output logic [DW-1:0] m_din,
    input  logic          hready,
    input  logic [DW-1:0] leitura
);

    state_t        r_state, w_state_nxt;
    logic          r_gnt0, r_gnt1, r_done0, r_done1, r_m_valid, r_wr, r_last;
    logic [AW-1:0] r_base;
    logic [2:0]    r_burst;
    logic [CW-1:0] r_len, r_beat_cnt;
    logic          w_sel, w_any, w_beat, w_last_beat;

    rr_pick2 u_pick (
        .req0 (req0),
        .req1 (req1),
        .last (r_last),
        .sel  (w_sel),
        .any  (w_any)
    );

    assign w_beat      = (r_state == BUSY) & hready;
    assign w_last_beat = w_beat & (r_beat_cnt == r_len - CW'(1));

    // Next-state decode: arbitrate in IDLE, run the burst, one idle turn cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = BUSY;
            BUSY:    if (w_last_beat) w_state_nxt = TURN;
            TURN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Command latch, beat counter, grants, done pulses and fairness memory.
    always_ff @(posedge hclk or negedge resetn) begin
        if (!resetn) begin
            r_gnt0     <= 1'b0;
            r_gnt1     <= 1'b0;
            r_done0    <= 1'b0;
            r_done1    <= 1'b0;
            r_m_valid  <= 1'b0;
            r_wr       <= 1'b0;
            r_last     <= 1'b1;
            r_base     <= '0;
            r_burst    <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_gnt0     <= ~w_sel;
                    r_gnt1     <= w_sel;
                    r_m_valid  <= 1'b1;
                    r_beat_cnt <= '0;
                    r_base     <= w_sel ? addr1  : addr0;
                    r_wr       <= w_sel ? wr1    : wr0;
                    r_burst    <= w_sel ? burst1 : burst0;
                    r_len      <= CW'(burst_len(w_sel ? burst1 : burst0));
                end
                BUSY: if (hready) begin
                    r_beat_cnt <= r_beat_cnt + CW'(1);
                    if (w_last_beat) begin
                        r_m_valid <= 1'b0;
                        r_gnt0    <= 1'b0;
                        r_gnt1    <= 1'b0;
                        r_done0   <= r_gnt0;
                        r_done1   <= r_gnt1;
                        r_last    <= r_gnt1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt0    = r_gnt0;
    assign gnt1    = r_gnt1;
    assign done0   = r_done0;
    assign done1   = r_done1;
    assign m_valid = r_m_valid;
    assign m_wr    = r_wr;
    assign m_burst = r_burst;
    // Address wraps naturally at the AW-bit boundary.
    assign m_addr  = r_base + AW'(r_beat_cnt);
    assign m_din   = r_gnt1 ? wdata1 : wdata0;
    assign ack0    = r_gnt0 & w_beat;
    assign ack1    = r_gnt1 & w_beat;
    assign rdata   = leitura;

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Self-checking bench for ahb_req_arbiter: directed scenarios followed by
// randomized transactions, all checked against a transaction-level model.
module tb_ahb_req_arbiter;

    logic        hclk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [10:0] addr0 = '0, addr1 = '0;
    logic        wr0 = 1'b0, wr1 = 1'b0;
    logic [2:0]  burst0 = '0, burst1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, ack0, ack1, done0, done1;
    logic [7:0]  rdata;
    logic        m_valid;
    logic [10:0] m_addr;
    logic        m_wr;
    logic [2:0]  m_burst;
    logic [7:0]  m_din;
    logic        hready = 1'b0;
    logic [7:0]  leitura = '0;

    int n_err = 0;
    int n_chk = 0;
    int last_w = 1;

    always #5 hclk = ~hclk;

    ahb_req_arbiter dut (
        .hclk(hclk), .resetn(resetn),
        .req0(req0), .addr0(addr0), .wr0(wr0), .burst0(burst0), .wdata0(wdata0),
        .req1(req1), .addr1(addr1), .wr1(wr1), .burst1(burst1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .done0(done0), .done1(done1), .rdata(rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wr(m_wr), .m_burst(m_burst),
        .m_din(m_din), .hready(hready), .leitura(leitura)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    // Burst length table for the model.
    function automatic int exp_len(input logic [2:0] bt);
        case (bt)
            3'b011:  return 4;
            3'b101:  return 8;
            3'b111:  return 16;
            default: return 1;
        endcase
    endfunction

    // Winner model: lone requester wins, a tie goes to whoever did not go last.
    function automatic int pick(input logic r0, input logic r1);
        if (r0 && r1) return (last_w == 0) ? 1 : 0;
        return r1 ? 1 : 0;
    endfunction

    // One full transaction from the grant edge through TURN into IDLE.
    // rnd=1: random stalls with probability pct%; rnd=0: mask bit c stalls cycle c.
    task automatic run_txn(input bit rnd, input logic [31:0] mask, input int pct);
        int who, len, k, c, acks;
        logic [10:0] base;
        logic        wrx, hr;
        logic [2:0]  bt;
        who  = pick(req0, req1);
        base = (who == 1) ? addr1 : addr0;
        wrx  = (who == 1) ? wr1 : wr0;
        bt   = (who == 1) ? burst1 : burst0;
        len  = exp_len(bt);
        tick;
        // Requester inputs wander during the burst; the latched command must not.
        req0 = 1'($urandom); req1 = 1'($urandom);
        addr0 = 11'($urandom); addr1 = 11'($urandom);
        wr0 = 1'($urandom); wr1 = 1'($urandom);
        burst0 = 3'($urandom); burst1 = 3'($urandom);
        k = 0; c = 0; acks = 0;
        while (k < len && c < 200) begin
            hr = rnd ? ($urandom_range(99) >= pct) : ~mask[c[4:0]];
            hready = hr;
            wdata0 = 8'($urandom); wdata1 = 8'($urandom); leitura = 8'($urandom);
            #1;
            chk("m_valid", 32'(m_valid), 32'd1);
            chk("gnt_own", 32'((who == 1) ? gnt1 : gnt0), 32'd1);
            chk("gnt_other", 32'((who == 1) ? gnt0 : gnt1), 32'd0);
            chk("m_addr", 32'(m_addr), (32'(base) + 32'(k)) & 32'h7FF);
            chk("m_wr", 32'(m_wr), 32'(wrx));
            chk("m_burst", 32'(m_burst), 32'(bt));
            chk("m_din", 32'(m_din), 32'((who == 1) ? wdata1 : wdata0));
            chk("ack_own", 32'((who == 1) ? ack1 : ack0), 32'(hr));
            chk("ack_other", 32'((who == 1) ? ack0 : ack1), 32'd0);
            chk("done_busy", 32'(done0 | done1), 32'd0);
            if (!wrx && hr) chk("rdata", 32'(rdata), 32'(leitura));
            if (((who == 1) ? ack1 : ack0) === 1'b1) acks++;
            if (hr) k++;
            c++;
            tick;
        end
        chk("burst_timeout", 32'(c < 200), 32'd1);
        chk("ack_count", 32'(acks), 32'(len));
        chk("done_own", 32'((who == 1) ? done1 : done0), 32'd1);
        chk("done_other", 32'((who == 1) ? done0 : done1), 32'd0);
        chk("turn_valid", 32'(m_valid), 32'd0);
        chk("turn_gnt", 32'(gnt0 | gnt1), 32'd0);
        last_w = who;
        tick;
        chk("idle_valid", 32'(m_valid), 32'd0);
        chk("done_clear", 32'(done0 | done1), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] codes [4];
        int sel;
        codes[0] = 3'b000; codes[1] = 3'b011; codes[2] = 3'b101; codes[3] = 3'b111;

        // Reset held with a request pending: nothing may be granted.
        req0 = 1'b1; addr0 = 11'h010; wr0 = 1'b1; burst0 = 3'b000; wdata0 = 8'hA5;
        tick; tick;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_addr", 32'(m_addr), 32'd0);
        chk("rst_done0", 32'(done0), 32'd0);
        chk("rst_m_wr", 32'(m_wr), 32'd0);
        chk("rst_m_burst", 32'(m_burst), 32'd0);
        @(negedge hclk);
        resetn = 1'b1;
        tick; tick;
        chk("rel_gnt0", 32'(gnt0), 32'd1);
        chk("rel_gnt1", 32'(gnt1), 32'd0);
        chk("rel_m_valid", 32'(m_valid), 32'd1);
        chk("stall_ack0", 32'(ack0), 32'd0);
        chk("single_addr", 32'(m_addr), 32'h010);
        // Single write completes once hready rises.
        hready = 1'b1;
        #1;
        chk("single_ack0", 32'(ack0), 32'd1);
        chk("single_din", 32'(m_din), 32'hA5);
        chk("single_wr", 32'(m_wr), 32'd1);
        req0 = 1'b0;
        tick;
        chk("single_done0", 32'(done0), 32'd1);
        chk("single_turn_valid", 32'(m_valid), 32'd0);
        chk("single_turn_gnt0", 32'(gnt0), 32'd0);
        last_w = 0;
        tick;
        chk("single_done_clr", 32'(done0), 32'd0);

        // INCR4 read from requester 1 across the address wrap, 2-cycle stall on beat 2.
        req0 = 1'b0; req1 = 1'b1; addr1 = 11'h7FE; wr1 = 1'b0; burst1 = 3'b011;
        run_txn(1'b0, 32'b110, 0);

        // Contention: both request singles, grants must alternate.
        for (int i = 0; i < 4; i++) begin
            req0 = 1'b1; req1 = 1'b1; burst0 = 3'b000; burst1 = 3'b000;
            addr0 = 11'($urandom); addr1 = 11'($urandom);
            wr0 = 1'($urandom); wr1 = 1'($urandom);
            run_txn(1'b0, 32'd0, 0);
        end

        // Reset in the middle of an INCR8 from requester 0.
        req0 = 1'b1; req1 = 1'b0; addr0 = 11'h123; wr0 = 1'b0; burst0 = 3'b101; hready = 1'b1;
        tick;
        tick; tick; tick;
        chk("mid_beat3_addr", 32'(m_addr), 32'h126);
        resetn = 1'b0;
        #1;
        chk("mid_gnt0", 32'(gnt0), 32'd0);
        chk("mid_gnt1", 32'(gnt1), 32'd0);
        chk("mid_m_valid", 32'(m_valid), 32'd0);
        chk("mid_m_addr", 32'(m_addr), 32'd0);
        chk("mid_m_wr", 32'(m_wr), 32'd0);
        chk("mid_ack0", 32'(ack0), 32'd0);
        chk("mid_done0", 32'(done0), 32'd0);
        req0 = 1'b0; req1 = 1'b1; addr1 = 11'h2A0; wr1 = 1'b1; burst1 = 3'b000;
        tick;
        chk("mid_no_done0", 32'(done0), 32'd0);
        last_w = 1;
        @(negedge hclk);
        resetn = 1'b1;
        run_txn(1'b1, 32'd0, 20);

        // Unsupported burst code behaves as a single beat.
        req0 = 1'b1; req1 = 1'b0; addr0 = 11'h055; wr0 = 1'b1; burst0 = 3'b010;
        run_txn(1'b0, 32'd0, 0);

        // Randomized traffic with random stalls.
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(2));
            req0 = (sel != 1); req1 = (sel != 0);
            addr0 = 11'($urandom); addr1 = 11'($urandom);
            wr0 = 1'($urandom); wr1 = 1'($urandom);
            burst0 = ($urandom_range(3) == 0) ? 3'($urandom) : codes[$urandom_range(3)];
            burst1 = ($urandom_range(3) == 0) ? 3'($urandom) : codes[$urandom_range(3)];
            run_txn(1'b1, 32'd0, 30);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
